// File: rtl/cam_ov7670_patgen.sv
// OV7670-style camera byte-stream pattern generator: RGB565 test patterns,
// high byte first, with VSYNC/HREF framing timed directly off clk.
module cam_ov7670_patgen #(
  parameter int H_ACTIVE   = 160,
  parameter int V_ACTIVE   = 120,
  parameter int H_BLANK    = 4,
  parameter int V_BLANK    = 4,
  parameter int VSYNC_ROWS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_px_data,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int LINE_LEN   = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_ROWS = V_BLANK + V_ACTIVE;
  localparam int HC_W       = $clog2(LINE_LEN);
  localparam int VC_W       = $clog2(FRAME_ROWS);
  localparam int BAR_W      = H_ACTIVE / 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [HC_W-1:0] hc_q, hc_d;
  logic [VC_W-1:0] vc_q, vc_d;
  logic            start_d;
  logic            last_byte;
  logic [1:0]      mode_q;
  logic [15:0]     color_q;

  assign last_byte = (hc_q == HC_W'(LINE_LEN - 1)) && (vc_q == VC_W'(FRAME_ROWS - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        hc_d = '0;
        vc_d = '0;
        if (enable) begin
          state_d = S_RUN;
          start_d = 1'b1;
        end
      end
      S_RUN, S_STOP: begin
        if (last_byte) begin
          // At the frame's last byte enable decides: wrap into a new frame or park.
          hc_d    = '0;
          vc_d    = '0;
          state_d = enable ? S_RUN : S_IDLE;
          start_d = enable;
        end else begin
          state_d = enable ? S_RUN : S_STOP;
          if (hc_q == HC_W'(LINE_LEN - 1)) begin
            hc_d = '0;
            vc_d = vc_q + VC_W'(1);
          end else begin
            hc_d = hc_q + HC_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        hc_d    = '0;
        vc_d    = '0;
      end
    endcase
  end

  // Outputs are computed from the next position so they register alongside it.
  logic        active_d, vsync_d, href_d;
  logic [15:0] x16, y16, bar_color, pix;
  logic [2:0]  bar_sel;
  logic [7:0]  byte_d;

  assign active_d = (state_d != S_IDLE);
  assign vsync_d  = active_d && (vc_d < VC_W'(VSYNC_ROWS));
  assign href_d   = active_d && (vc_d >= VC_W'(V_BLANK)) && (hc_d < HC_W'(2 * H_ACTIVE));
  assign x16      = 16'(hc_d >> 1);
  assign y16      = 16'(vc_d) - 16'(V_BLANK);
  assign bar_sel  = 3'(x16 / 16'(BAR_W));

  always_comb begin
    bar_color = 16'h0000;
    unique case (bar_sel)
      3'd0: bar_color = 16'hFFFF;
      3'd1: bar_color = 16'hFFE0;
      3'd2: bar_color = 16'h07FF;
      3'd3: bar_color = 16'h07E0;
      3'd4: bar_color = 16'hF81F;
      3'd5: bar_color = 16'hF800;
      3'd6: bar_color = 16'h001F;
      3'd7: bar_color = 16'h0000;
      default: bar_color = 16'h0000;
    endcase
  end

  // Captured mode/colour/count only change at vc=0, where href is low, so the
  // registered copies are always the ones belonging to the byte being built.
  always_comb begin
    pix = 16'h0000;
    unique case (mode_q)
      2'd0: pix = color_q;
      2'd1: pix = bar_color;
      2'd2: pix = x16 + y16 + {8'h00, frame_cnt};
      2'd3: pix = (x16[3] ^ y16[3]) ? 16'hFFFF : 16'h0000;
      default: pix = 16'h0000;
    endcase
    byte_d = 8'h00;
    if (href_d) byte_d = hc_d[0] ? pix[7:0] : pix[15:8];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      hc_q        <= '0;
      vc_q        <= '0;
      mode_q      <= 2'd0;
      color_q     <= 16'h0000;
      CAM_vsync   <= 1'b0;
      CAM_href    <= 1'b0;
      CAM_px_data <= 8'h00;
      frame_start <= 1'b0;
      frame_cnt   <= 8'h00;
    end else begin
      state_q     <= state_d;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      CAM_vsync   <= vsync_d;
      CAM_href    <= href_d;
      CAM_px_data <= byte_d;
      frame_start <= start_d;
      if (start_d) begin
        frame_cnt <= frame_cnt + 8'd1;
        mode_q    <= mode;
        color_q   <= solid_color;
      end
    end
  end

endmodule
